// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel arbitrating multiplexer with valid/ready handshakes.
// Selects one requesting channel per cycle (round-robin, fixed priority, or a
// forced channel) and captures its payload into a one-entry output register.
// The register can be drained and reloaded on the same edge, so sustained
// throughput is one word per cycle.
module rr_arb_mux #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 32,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_CH-1:0]        InValid,
  input  logic [NUM_CH*DATA_W-1:0] InData,
  output logic [NUM_CH-1:0]        InReady,
  input  logic                     Mode,
  input  logic                     ForceEn,
  input  logic [CH_W-1:0]          ForceSel,
  output logic                     OutValid,
  output logic [DATA_W-1:0]        OutData,
  output logic [CH_W-1:0]          OutChannel,
  input  logic                     OutReady
);

  // Output register and round-robin pointer.
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CH_W-1:0]   r_out_ch;
  logic [CH_W-1:0]   r_ptr;

  // Arbitration nets.
  logic [NUM_CH-1:0] w_elig;
  logic              w_grant_any;
  logic [CH_W-1:0]   w_grant_idx;
  logic [CH_W-1:0]   w_cand;
  logic              w_load;
  logic              w_take;
  logic [NUM_CH-1:0] w_ready;
  logic [DATA_W-1:0] w_sel_data;

  // Channel index (base + off) wrapped modulo NUM_CH; off is at most NUM_CH-1.
  function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    sum = (sum >= NUM_CH) ? (sum - NUM_CH) : sum;
    return sum[CH_W-1:0];
  endfunction

  // Eligibility: valid requests, narrowed to ForceSel when forcing. An
  // out-of-range ForceSel matches no channel, so nothing is eligible.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_elig[i] = InValid[i] & (~ForceEn | (int'(ForceSel) == i));
    end
  end

  // Grant search: walk candidates from the farthest to the nearest so the
  // nearest eligible one is written last and wins. Round-robin starts at the
  // pointer; fixed priority starts at channel 0.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_cand      = Mode ? CH_W'(k) : wrap_inc(r_ptr, k);
      w_grant_any = w_grant_any | w_elig[w_cand];
      w_grant_idx = w_elig[w_cand] ? w_cand : w_grant_idx;
    end
  end

  // The register takes a word when empty or draining this cycle; nothing is
  // accepted while Reset is high since the capture would be discarded.
  assign w_load = ~Reset & (~r_out_valid | OutReady);
  assign w_take = w_load & w_grant_any;

  // One-hot accept and payload select for the granted channel.
  always_comb begin
    w_ready    = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_ready[i] = w_take & (w_grant_idx == CH_W'(i));
      w_sel_data = w_sel_data |
                   (InData[i*DATA_W +: DATA_W] & {DATA_W{w_grant_idx == CH_W'(i)}});
    end
  end

  assign InReady = w_ready;

  // Output register and pointer update; a drain without reload only clears
  // the valid flag so data/channel keep their last values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_take) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_ch    <= w_grant_idx;
        if (!Mode && !ForceEn) begin
          r_ptr <= wrap_inc(w_grant_idx, 1);
        end else begin
          r_ptr <= r_ptr;
        end
      end else if (OutReady) begin
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_out_valid;
      end
    end
  end

  assign OutValid   = r_out_valid;
  assign OutData    = r_out_data;
  assign OutChannel = r_out_ch;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: vector table plus hand-written sequences for rr_arb_mux
// (NUM_CH=3, DATA_W=32). Granted words are queued when accepted and popped
// when they appear on the output register one cycle later.
module tb_rr_arb_mux;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 32;
  localparam int CH_W   = 2;

  logic                     Clk;
  logic                     Reset;
  logic [NUM_CH-1:0]        InValid;
  logic [NUM_CH*DATA_W-1:0] InData;
  logic [NUM_CH-1:0]        InReady;
  logic                     Mode;
  logic                     ForceEn;
  logic [CH_W-1:0]          ForceSel;
  logic                     OutValid;
  logic [DATA_W-1:0]        OutData;
  logic [CH_W-1:0]          OutChannel;
  logic                     OutReady;

  typedef struct packed {
    logic [2:0] valid;
    logic       mode;
    logic       fen;
    logic [1:0] fsel;
    logic       ordy;
    logic [2:0] exp_rdy;
    logic       exp_ov;
  } vec_t;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] data;
  } sb_item_t;

  vec_t        tbl [24];
  sb_item_t    sb_q [$];
  logic [31:0] ch_data [3];
  logic        pending = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  rr_arb_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InData(InData),
    .InReady(InReady), .Mode(Mode), .ForceEn(ForceEn), .ForceSel(ForceSel),
    .OutValid(OutValid), .OutData(OutData), .OutChannel(OutChannel),
    .OutReady(OutReady)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
    return oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
  endfunction

  task automatic set_data(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    ch_data[0] = d0;
    ch_data[1] = d1;
    ch_data[2] = d2;
    InData = {d2, d1, d0};
  endtask

  task automatic drive(input logic [2:0] v, input logic m, input logic fe,
                       input logic [1:0] fs, input logic ordy);
    InValid  = v;
    Mode     = m;
    ForceEn  = fe;
    ForceSel = fs;
    OutReady = ordy;
  endtask

  // Let the combinational grant settle, check InReady, queue the expected word.
  task automatic settle(input string nm, input logic [2:0] exp_rdy);
    sb_item_t it;
    #4;
    check($sformatf("%s.in_ready", nm), 32'(InReady), 32'(exp_rdy));
    pending = (exp_rdy != 3'b000);
    if (pending) begin
      it.ch   = onehot_idx(exp_rdy);
      it.data = ch_data[it.ch];
      sb_q.push_back(it);
    end
  endtask

  // Cross the active edge and compare the registered outputs.
  task automatic clk_edge(input string nm, input logic exp_ov);
    sb_item_t it;
    @(posedge Clk);
    #1;
    check($sformatf("%s.out_valid", nm), 32'(OutValid), 32'(exp_ov));
    if (pending) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s.scoreboard: actual=empty required=entry", nm);
      end else begin
        it = sb_q.pop_front();
        check($sformatf("%s.out_data", nm), OutData, it.data);
        check($sformatf("%s.out_channel", nm), 32'(OutChannel), 32'(it.ch));
      end
    end
    pending = 1'b0;
  endtask

  initial begin
    // valid, mode, fen, fsel, ordy, exp_rdy, exp_ov
    // Round-robin fairness, pointer 0 -> 1 -> 2 -> 0 ...
    tbl[0]  = '{3'b111, 1'b0, 1'b0, 2'd0, 1'b1, 3'b001, 1'b1};
    tbl[1]  = '{3'b111, 1'b0, 1'b0, 2'd0, 1'b1, 3'b010, 1'b1};
    tbl[2]  = '{3'b111, 1'b0, 1'b0, 2'd0, 1'b1, 3'b100, 1'b1};
    tbl[3]  = '{3'b111, 1'b0, 1'b0, 2'd0, 1'b1, 3'b001, 1'b1};
    tbl[4]  = '{3'b111, 1'b0, 1'b0, 2'd0, 1'b1, 3'b010, 1'b1};
    tbl[5]  = '{3'b111, 1'b0, 1'b0, 2'd0, 1'b1, 3'b100, 1'b1};
    // Fixed priority: ch1 beats ch2, drop ch1 -> ch2, pointer untouched (0)
    tbl[6]  = '{3'b110, 1'b1, 1'b0, 2'd0, 1'b1, 3'b010, 1'b1};
    tbl[7]  = '{3'b100, 1'b1, 1'b0, 2'd0, 1'b1, 3'b100, 1'b1};
    tbl[8]  = '{3'b110, 1'b1, 1'b0, 2'd0, 1'b1, 3'b010, 1'b1};
    tbl[9]  = '{3'b111, 1'b0, 1'b0, 2'd0, 1'b1, 3'b001, 1'b1};
    // Pointer wrap: grant 2 wraps pointer to 0, grant 0 moves it to 1
    tbl[10] = '{3'b100, 1'b0, 1'b0, 2'd0, 1'b1, 3'b100, 1'b1};
    tbl[11] = '{3'b001, 1'b0, 1'b0, 2'd0, 1'b1, 3'b001, 1'b1};
    tbl[12] = '{3'b111, 1'b0, 1'b0, 2'd0, 1'b1, 3'b010, 1'b1};
    tbl[13] = '{3'b001, 1'b0, 1'b0, 2'd0, 1'b1, 3'b001, 1'b1};
    // Force ch2 with pointer at 1; pointer must still be 1 afterwards
    tbl[14] = '{3'b111, 1'b0, 1'b1, 2'd2, 1'b1, 3'b100, 1'b1};
    tbl[15] = '{3'b111, 1'b0, 1'b1, 2'd2, 1'b1, 3'b100, 1'b1};
    tbl[16] = '{3'b111, 1'b0, 1'b0, 2'd0, 1'b1, 3'b010, 1'b1};
    // Out-of-range forced channel: nothing granted, register drains
    tbl[17] = '{3'b111, 1'b0, 1'b1, 2'd3, 1'b1, 3'b000, 1'b0};
    tbl[18] = '{3'b111, 1'b0, 1'b1, 2'd3, 1'b1, 3'b000, 1'b0};
    tbl[19] = '{3'b000, 1'b0, 1'b0, 2'd0, 1'b1, 3'b000, 1'b0};
    // Empty register loads even with OutReady=0, then stalls, then reloads
    tbl[20] = '{3'b010, 1'b0, 1'b0, 2'd0, 1'b0, 3'b010, 1'b1};
    tbl[21] = '{3'b010, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 1'b1};
    tbl[22] = '{3'b010, 1'b0, 1'b0, 2'd0, 1'b1, 3'b010, 1'b1};
    tbl[23] = '{3'b000, 1'b0, 1'b0, 2'd0, 1'b1, 3'b000, 1'b0};

    // Reset state, with requests present to show no accept during reset.
    Reset = 1'b1;
    set_data(32'h0000_00A0, 32'h0000_00B1, 32'h0000_00C2);
    drive(3'b111, 1'b0, 1'b0, 2'd0, 1'b1);
    @(posedge Clk);
    #1;
    check("reset.out_valid", 32'(OutValid), 32'h0);
    check("reset.out_data", OutData, 32'h0);
    check("reset.out_channel", 32'(OutChannel), 32'h0);
    check("reset.in_ready", 32'(InReady), 32'h0);
    Reset = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].valid, tbl[i].mode, tbl[i].fen, tbl[i].fsel, tbl[i].ordy);
      settle($sformatf("row%0d", i), tbl[i].exp_rdy);
      clk_edge($sformatf("row%0d", i), tbl[i].exp_ov);
    end

    // Backpressure: first word 0x11 from ch0 (pointer at 2 wraps to ch0).
    set_data(32'h0000_0011, 32'h0000_0022, 32'h0000_0033);
    drive(3'b001, 1'b0, 1'b0, 2'd0, 1'b1);
    settle("bp_first", 3'b001);
    clk_edge("bp_first", 1'b1);
    for (int s = 0; s < 4; s++) begin
      drive(3'b011, 1'b0, 1'b0, 2'd0, 1'b0);
      settle($sformatf("bp_stall%0d", s), 3'b000);
      clk_edge($sformatf("bp_stall%0d", s), 1'b1);
      check($sformatf("bp_stall%0d.out_data", s), OutData, 32'h0000_0011);
      check($sformatf("bp_stall%0d.out_channel", s), 32'(OutChannel), 32'h0);
    end
    // Release: 0x11 drains and ch1 (pointer at 1) loads on the same edge.
    drive(3'b011, 1'b0, 1'b0, 2'd0, 1'b1);
    settle("bp_release", 3'b010);
    clk_edge("bp_release", 1'b1);

    // Reset mid-stream while a word is held: immediate clear.
    drive(3'b111, 1'b0, 1'b0, 2'd0, 1'b0);
    #1;
    Reset = 1'b1;
    #1;
    check("midrst.out_valid", 32'(OutValid), 32'h0);
    check("midrst.out_data", OutData, 32'h0);
    check("midrst.out_channel", 32'(OutChannel), 32'h0);
    check("midrst.in_ready", 32'(InReady), 32'h0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    drive(3'b000, 1'b0, 1'b0, 2'd0, 1'b1);
    pending = 1'b0;
    for (int s = 0; s < 3; s++) begin
      clk_edge($sformatf("idle%0d", s), 1'b0);
    end
    // Pointer restarts at 0 after reset.
    drive(3'b111, 1'b0, 1'b0, 2'd0, 1'b1);
    settle("post_rst", 3'b001);
    clk_edge("post_rst", 1'b1);
    drive(3'b000, 1'b0, 1'b0, 2'd0, 1'b1);
    settle("final_drain", 3'b000);
    clk_edge("final_drain", 1'b0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
